mem_port_arbiter: RTL and testbench

Sequences and shares the single unified instruction/data memory between the CPU control FSM and a DMA/loader port. Each requester issues one word access at a time over a req/ack handshake. The arbiter selects an owner, issues exactly one memory cycle, waits out the fixed memory read latency, and returns read data with a one-cycle ack. The CPU control FSM holds its current state (fetch, memory read or memory write) until `cpu_ack`.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_pick.sv | 28 ++
 rtl/mem_port_arbiter.sv | 109 ++++++++++
 tb/tb_mem_port_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  localparam int LAT_MAX = 7;
  localparam int CNT_W   = 3;
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Owner selection for the memory arbiter. MEM_ARB_RR_EN selects round-robin
// on a tie; otherwise the CPU always has priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic cpu_req,
  input  logic dma_req,
  input  logic owner,
  output logic any,
  output logic grant
);

  assign any = cpu_req | dma_req;

`ifdef MEM_ARB_RR_EN
  // On a tie the previous loser wins; a lone requester always wins.
  always_comb begin
    grant = OWN_CPU;
    if (cpu_req && dma_req) grant = ~owner;
    else if (dma_req)       grant = OWN_DMA;
  end
`else
  logic unused_owner;
  assign unused_owner = owner;
  assign grant = cpu_req ? OWN_CPU : OWN_DMA;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the CPU control FSM and the DMA/loader.
// Arbitration policy lives in mem_arb_pick (MEM_ARB_RR_EN for round-robin).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  if (MEM_LAT < 1 || MEM_LAT > LAT_MAX) begin : g_bad_lat
    $error("mem_port_arbiter: MEM_LAT out of range 1..7");
  end

  localparam cnt_t LAT = cnt_t'(MEM_LAT);

  state_t state, state_nxt;
  logic   own_q, we_q;
  cnt_t   cnt;
  logic   any, grant;

  mem_arb_pick u_pick (
    .cpu_req (cpu_req),
    .dma_req (dma_req),
    .owner   (own_q),
    .any     (any),
    .grant   (grant)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any) state_nxt = ISSUE;
      ISSUE:   state_nxt = we_q ? RESP : WAIT;
      WAIT:    if (cnt == cnt_t'(1)) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_en  = (state == ISSUE);
    mem_we  = mem_en & we_q;
    busy    = (state != IDLE);
    cpu_ack = (state == RESP) && (own_q == OWN_CPU);
    dma_ack = (state == RESP) && (own_q == OWN_DMA);
    owner   = own_q;
  end

  // Request fields are latched at grant so the memory sees stable values
  // regardless of what the requester does afterwards.
  always_ff @(posedge clk) begin
    if (!reset) begin
      own_q     <= OWN_DMA;
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cnt       <= '0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      case (state)
        IDLE: if (any) begin
          own_q     <= grant;
          we_q      <= (grant == OWN_DMA) ? dma_we    : cpu_we;
          mem_addr  <= (grant == OWN_DMA) ? dma_addr  : cpu_addr;
          mem_wdata <= (grant == OWN_DMA) ? dma_wdata : cpu_wdata;
        end
        ISSUE: cnt <= LAT;
        WAIT: begin
          cnt <= cnt - cnt_t'(1);
          if (cnt == cnt_t'(1)) begin
            if (own_q == OWN_DMA) dma_rdata <= mem_rdata;
            else                  cpu_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: transaction-level timing model plus
// a reference memory, with an independent monitor; a second MEM_LAT=4 instance.
module tb_mem_port_arbiter;

  localparam int LAT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- main DUT (MEM_LAT = 1) ----------------
  logic        reset;
  logic        rq [2];
  logic        rwe [2];
  logic [31:0] raddr [2];
  logic [31:0] rwd [2];
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_ack, dma_ack, mem_en, mem_we, busy, owner;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(rq[0]), .cpu_we(rwe[0]), .cpu_addr(raddr[0]), .cpu_wdata(rwd[0]),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dma_req(rq[1]), .dma_we(rwe[1]), .dma_addr(raddr[1]), .dma_wdata(rwd[1]),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  function automatic logic [31:0] init_word(int i);
    return 32'h5A00_0000 ^ 32'(i * 7919);
  endfunction

  // Behavioural memory: read data valid only in cycle issue+LAT.
  logic [31:0] tmem [256];
  logic [7:0]  rdi = '0;
  int          due = -1;
  assign mem_rdata = (cyc == due) ? tmem[rdi] : (32'hBAD0_0000 ^ 32'(cyc));

  initial begin
    for (int i = 0; i < 256; i++) tmem[i] = init_word(i);
    tmem[8'h10] = 32'hDEADBEEF;
    forever begin
      @(negedge clk);
      if (mem_en === 1'b1) begin
        if (mem_we) tmem[mem_addr[9:2]] = mem_wdata;
        else begin rdi = mem_addr[9:2]; due = cyc + LAT; end
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct { int port; int cyc; bit we; logic [31:0] data; } ack_t;
  typedef struct { int cyc; bit we; logic [31:0] addr; logic [31:0] data; } iss_t;

  ack_t        aq [$];
  iss_t        iq [$];
  logic [31:0] rmem [256];
  int          ack_at [2];
  int          free_at = 0;
  int          last_own = 1;
  int          busy_lo = 0, busy_hi = -1;
  int          own_from = 0, own_cur = 1, own_prev = 1;
  int          rst_at = -1;
  bit          mon_on = 0;
  bit          dut4_done = 0;

  function automatic int pick(logic c, logic d, int last);
`ifdef MEM_ARB_RR_EN
    if (c && d) return (last == 0) ? 1 : 0;
`endif
    return c ? 0 : 1;
  endfunction

  // Model for cycle `cyc`: requesters drop at their ack, then a free arbiter grants.
  task automatic model_step(bit in_rst);
    int k, g, ackc;
    logic [31:0] v;
    k = cyc;
    for (int p = 0; p < 2; p++)
      if (rq[p] && ack_at[p] == k) begin rq[p] = 1'b0; ack_at[p] = -1; end
    if (!in_rst && k >= free_at && (rq[0] || rq[1])) begin
      g    = pick(rq[0], rq[1], last_own);
      ackc = k + 2 + (rwe[g] ? 0 : LAT);
      v    = '0;
      if (rwe[g]) rmem[raddr[g][9:2]] = rwd[g];
      else        v = rmem[raddr[g][9:2]];
      aq.push_back('{port:g, cyc:ackc, we:rwe[g], data:v});
      iq.push_back('{cyc:k+1, we:rwe[g], addr:raddr[g], data:rwd[g]});
      ack_at[g] = ackc;
      free_at   = ackc + 1;
      last_own  = g;
      own_prev  = own_cur; own_cur = g; own_from = k + 1;
      busy_lo   = k + 1;   busy_hi = ackc;
    end
  endtask

  task automatic tick(bit in_rst);
    model_step(in_rst);
    @(negedge clk); #1;
  endtask

  task automatic raise(int p, bit we, logic [31:0] a, logic [31:0] d);
    int n = 0;
    while (rq[p] && n < 200) begin tick(0); n++; end
    rwe[p] = we; raddr[p] = a; rwd[p] = d; rq[p] = 1'b1;
  endtask

  task automatic settle();
    int n = 0;
    while ((rq[0] || rq[1] || cyc < free_at) && n < 500) begin tick(0); n++; end
    repeat (2) tick(0);
  endtask

  // Reset held low for exactly one cycle; any in-flight transaction is abandoned.
  task automatic do_reset();
    int k = cyc;
    reset = 1'b0;
    aq.delete(); iq.delete();
    for (int p = 0; p < 2; p++) begin rq[p] = 1'b0; ack_at[p] = -1; end
    last_own = 1;
    own_prev = own_cur; own_cur = 1; own_from = k + 1;
    if (busy_hi > k) busy_hi = k;
    free_at = k + 1;
    rst_at  = k + 1;
    tick(1);
    reset = 1'b1;
  endtask

  // ---------------- monitor ----------------
  logic [31:0] hold [2];
  int          last_en = -1;
  bit          last_en_we = 0;

  initial begin
    hold[0] = '0; hold[1] = '0;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        automatic int k = cyc;
        if (k == rst_at) begin hold[0] = '0; hold[1] = '0; last_en = -1; end
        while (aq.size() > 0 && aq[0].cyc < k) begin
          chk("ack_missing", 32'(aq[0].cyc), 32'(k));
          void'(aq.pop_front());
        end
        for (int p = 0; p < 2; p++) begin
          automatic logic a  = (p == 0) ? cpu_ack : dma_ack;
          automatic bit   ex = aq.size() > 0 && aq[0].cyc == k && aq[0].port == p;
          chk(p == 0 ? "cpu_ack" : "dma_ack", 32'(a), 32'(ex));
          if (a && ex) begin
            if (!aq[0].we) hold[p] = aq[0].data;
            void'(aq.pop_front());
          end
        end
        chk("cpu_rdata", cpu_rdata, hold[0]);
        chk("dma_rdata", dma_rdata, hold[1]);
        while (iq.size() > 0 && iq[0].cyc < k) begin
          chk("issue_missing", 32'(iq[0].cyc), 32'(k));
          void'(iq.pop_front());
        end
        begin
          automatic bit ex = iq.size() > 0 && iq[0].cyc == k;
          chk("mem_en", 32'(mem_en), 32'(ex));
          if (mem_en && ex) begin
            chk("mem_we", 32'(mem_we), 32'(iq[0].we));
            chk("mem_addr", mem_addr, iq[0].addr);
            if (iq[0].we) chk("mem_wdata", mem_wdata, iq[0].data);
            void'(iq.pop_front());
          end
        end
        if (mem_en) begin
          if (last_en >= 0)
            chk("en_spacing_ok", 32'(k - last_en >= (last_en_we ? 3 : 3 + LAT)), 32'd1);
          last_en = k; last_en_we = mem_we;
        end
        chk("busy", 32'(busy), 32'(k >= busy_lo && k <= busy_hi));
        chk("owner", 32'(owner), 32'(k >= own_from ? own_cur : own_prev));
      end
    end
  end

  // ---------------- second instance, MEM_LAT = 4 ----------------
  logic        reset4, c4_req, c4_ack, d4_ack, en4, we4, busy4, own4;
  logic [31:0] c4_addr, c4_rdata, d4_rdata, addr4, wdata4, rdata4;
  int          due4 = -1;
  logic [31:0] a4 = '0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(4)) u_dut4 (
    .clk(clk), .reset(reset4),
    .cpu_req(c4_req), .cpu_we(1'b0), .cpu_addr(c4_addr), .cpu_wdata(32'h0),
    .cpu_rdata(c4_rdata), .cpu_ack(c4_ack),
    .dma_req(1'b0), .dma_we(1'b0), .dma_addr(32'h0), .dma_wdata(32'h0),
    .dma_rdata(d4_rdata), .dma_ack(d4_ack),
    .mem_en(en4), .mem_we(we4), .mem_addr(addr4), .mem_wdata(wdata4),
    .mem_rdata(rdata4), .busy(busy4), .owner(own4)
  );

  assign rdata4 = (cyc == due4) ? (a4 ^ 32'hC0DE_0000) : 32'hBAD4_BAD4;

  initial begin
    forever begin
      @(negedge clk);
      if (en4 === 1'b1 && we4 === 1'b0) begin a4 = addr4; due4 = cyc + 4; end
    end
  end

  initial begin
    reset4 = 1'b0; c4_req = 1'b0; c4_addr = '0;
    repeat (3) @(negedge clk);
    reset4 = 1'b1;
    c4_req = 1'b1; c4_addr = 32'h80;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("lat4_mem_en", 32'(en4), 32'(i == 1));
      chk("lat4_busy", 32'(busy4), 32'(i <= 6));
      chk("lat4_cpu_ack", 32'(c4_ack), 32'(i == 6));
      chk("lat4_dma_ack", 32'(d4_ack), 32'd0);
      if (i == 6) begin
        chk("lat4_rdata", c4_rdata, 32'hC0DE_0080);
        c4_req = 1'b0;
      end
    end
    dut4_done = 1;
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    for (int i = 0; i < 256; i++) rmem[i] = init_word(i);
    rmem[8'h10] = 32'hDEADBEEF;
    for (int p = 0; p < 2; p++) begin
      rq[p] = 1'b0; rwe[p] = 1'b0; raddr[p] = '0; rwd[p] = '0; ack_at[p] = -1;
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    reset   = 1'b1;
    free_at = cyc;
    mon_on  = 1;

    raise(0, 0, 32'h40, 32'h0);                 settle();
    raise(1, 1, 32'h100, 32'h12345678);         settle();
    raise(0, 0, 32'h100, 32'h0);                settle();

    do_reset(); tick(0);
    repeat (2) begin
      raise(0, 0, 32'h200, 32'h0);
      raise(1, 0, 32'h204, 32'h0);
      settle();
    end

    raise(1, 0, 32'h300, 32'h0);
    tick(0); tick(0);
    do_reset();
    repeat (6) tick(0);

    raise(0, 0, 32'h40, 32'h0);
    tick(0); tick(0);
    raise(1, 1, 32'h104, $urandom);
    settle();

    for (int c = 0; c < 1500; c++) begin
      for (int p = 0; p < 2; p++)
        if (!rq[p] && $urandom_range(0, 2) == 0) begin
          rwe[p]   = $urandom_range(0, 1);
          raddr[p] = 32'h300 + 32'($urandom_range(0, 15)) * 4;
          rwd[p]   = $urandom;
          rq[p]    = 1'b1;
        end
      if ($urandom_range(0, 299) == 0) do_reset();
      else tick(0);
    end
    settle();
    repeat (4) tick(0);
    chk("ack_queue_drained", 32'(aq.size()), 32'd0);
    chk("issue_queue_drained", 32'(iq.size()), 32'd0);

    n = 0;
    while (!dut4_done && n < 100) begin @(negedge clk); n++; end
    chk("lat4_finished", 32'(dut4_done), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
